// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle 8-bit ALU front-ends: op codes,
// sequencer state encoding and the per-op operand word count.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Divide loads A, Q, M; the other ops load Q, M and the ALU zeroes A itself.
  function automatic logic [1:0] words_for_op(input logic [1:0] op);
    return (op == OP_DIV) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/alu_outbus_capture.sv
// Two-deep history of the ALU result bus: h1 is last cycle's outbus, h0 the
// cycle before that. Clear wins over shift so a new operation starts from zeros.
module alu_outbus_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift,
  input  logic [7:0] outbus,
  output logic [7:0] h0,
  output logic [7:0] h1
);

  // NOTE: non-blocking assignments make h0 take the old h1, not this cycle's outbus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h0 <= 8'h00;
      h1 <= 8'h00;
    end else if (clear) begin
      h0 <= 8'h00;
      h1 <= 8'h00;
    end else if (shift) begin
      h1 <= outbus;
      h0 <= h1;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Request/response front-end for the multi-cycle ALU: pulses BEGIN, serialises
// the operand words onto inbus, and returns the two result words seen before END.
module alu_operand_sequencer #(
  parameter int FEED_DELAY     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_q,
  input  logic [7:0] req_m,
  output logic       alu_begin,
  output logic [1:0] alu_op_code,
  output logic [7:0] alu_inbus,
  input  logic [7:0] alu_outbus,
  input  logic       alu_end,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_hi,
  output logic [7:0] rsp_lo,
  output logic       rsp_timeout,
  output logic       busy
);
  import alu_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FC_W = $clog2(FEED_DELAY + 4);

  logic [2:0]      state;
  logic [1:0]      op;
  logic [7:0]      word_a, word_q, word_m;
  logic [FC_W-1:0] feed_cnt;
  logic [FC_W-1:0] feed_last;
  logic [WD_W-1:0] wd;
  logic            wd_expire;
  logic            feeding;
  logic [1:0]      slot;
  logic [7:0]      h0, h1;

  alu_outbus_capture u_capture (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_START),
    .shift  ((state == ST_FEED) || (state == ST_RUN)),
    .outbus (alu_outbus),
    .h0     (h0),
    .h1     (h1)
  );

  assign feed_last = FC_W'(FEED_DELAY) + FC_W'(words_for_op(op)) - FC_W'(1);
  assign feeding   = (state == ST_FEED) && (feed_cnt >= FC_W'(FEED_DELAY));
  // Non-divide ops skip the A slot, so their first word maps to Q.
  assign slot      = 2'(feed_cnt - FC_W'(FEED_DELAY)) + ((op == OP_DIV) ? 2'd0 : 2'd1);
  // wd is 0 on START+1, so it holds TIMEOUT_CYCLES-1 on the last allowed cycle.
  assign wd_expire = (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // NOTE: default assignment first so no path leaves alu_inbus unassigned (no latch).
  always_comb begin
    alu_inbus = 8'h00;
    if (feeding) begin
      case (slot)
        2'd0:    alu_inbus = word_a;
        2'd1:    alu_inbus = word_q;
        default: alu_inbus = word_m;
      endcase
    end
  end

  assign req_ready   = reset && (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign alu_begin   = (state == ST_START);
  assign alu_op_code = busy ? op : 2'b00;
  assign rsp_valid   = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      op          <= 2'b00;
      word_a      <= 8'h00;
      word_q      <= 8'h00;
      word_m      <= 8'h00;
      feed_cnt    <= '0;
      wd          <= '0;
      rsp_hi      <= 8'h00;
      rsp_lo      <= 8'h00;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op     <= req_op;
            word_a <= req_a;
            word_q <= req_q;
            word_m <= req_m;
            state  <= ST_START;
          end
        end
        ST_START: begin
          wd       <= '0;
          feed_cnt <= '0;
          state    <= ST_FEED;
        end
        ST_FEED, ST_RUN: begin
          wd <= wd + 1'b1;
          if (state == ST_FEED) begin
            feed_cnt <= feed_cnt + 1'b1;
            if (feed_cnt == feed_last) state <= ST_RUN;
          end
          // END may arrive while still feeding; it also beats a same-cycle timeout.
          if (alu_end) begin
            rsp_hi      <= h0;
            rsp_lo      <= h1;
            rsp_timeout <= 1'b0;
            state       <= ST_DONE;
          end else if (wd_expire) begin
            rsp_hi      <= 8'h00;
            rsp_lo      <= 8'h00;
            rsp_timeout <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: scripted ALU model on the ALU side, scoreboard of
// expected responses on the request/response side.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  localparam int TIMEOUT_CYCLES = 64;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       to;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_q, req_m;
  logic       alu_begin;
  logic [1:0] alu_op_code;
  logic [7:0] alu_inbus, alu_outbus;
  logic       alu_end;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_hi, rsp_lo;
  logic       rsp_timeout, busy;

  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t sb[$];

  alu_operand_sequencer #(.FEED_DELAY(1), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_q       (req_q),
    .req_m       (req_m),
    .alu_begin   (alu_begin),
    .alu_op_code (alu_op_code),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_end     (alu_end),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_hi      (rsp_hi),
    .rsp_lo      (rsp_lo),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result words the model ALU pushes onto outbus: {hi, lo}.
  function automatic void alu_model(input logic [1:0] op, input logic [7:0] a, q, m,
                                    output logic [7:0] hi, output logic [7:0] lo);
    logic [15:0] r;
    logic [15:0] dvd;
    dvd = {a, q};
    case (op)
      OP_ADD:  r = 16'({1'b0, q} + {1'b0, m});
      OP_SUB:  r = {8'h00, q - m};
      OP_MUL:  r = 16'(q) * 16'(m);
      default: r = (m == 8'h00) ? 16'hFFFF : {8'(dvd % 16'(m)), 8'(dvd / 16'(m))};
    endcase
    hi = r[15:8];
    lo = r[7:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_alu_begin"}, alu_begin, 1'b0);
    check({tag, "_alu_op_code"}, alu_op_code, 2'b00);
    check({tag, "_alu_inbus"}, alu_inbus, 8'h00);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_hi"}, rsp_hi, 8'h00);
    check({tag, "_rsp_lo"}, rsp_lo, 8'h00);
    check({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Starts on a negedge with the DUT in IDLE; returns on the negedge after the
  // response handshake (DUT back in IDLE). end_at is the END cycle counted from
  // BEGIN (0); end_at < 1 means the model never raises END. During the hold
  // cycles a junk request and a stray END are driven and must be ignored.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, q, m,
                       input int end_at, input int hold);
    logic [7:0] r_hi, r_lo, w;
    logic [7:0] words [3];
    int   n, done_at;
    bit   ended;
    rsp_t exp_rsp;
    alu_model(op, a, q, m, r_hi, r_lo);
    if (op == OP_DIV) begin
      words[0] = a; words[1] = q; words[2] = m; n = 3;
    end else begin
      words[0] = q; words[1] = m; words[2] = 8'h00; n = 2;
    end
    ended   = (end_at >= 1) && (end_at <= TIMEOUT_CYCLES);
    done_at = ended ? end_at : TIMEOUT_CYCLES;
    exp_rsp.hi = (ended && end_at >= 3) ? r_hi : 8'h00;
    exp_rsp.lo = (ended && end_at >= 2) ? r_lo : 8'h00;
    exp_rsp.to = !ended;
    sb.push_back(exp_rsp);

    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_q = q; req_m = m;
    @(negedge clk);
    req_valid = 1'b0;
    check("alu_begin", alu_begin, 1'b1);
    check("alu_op_code", alu_op_code, op);
    check("busy", busy, 1'b1);
    alu_end    = 1'b0;
    alu_outbus = (end_at == 2) ? r_hi : 8'hEE;
    for (int k = 1; k <= done_at; k++) begin
      @(negedge clk);
      if (k == 1) check("alu_begin_once", alu_begin, 1'b0);
      if (k <= n + 2) begin
        w = (k >= 2 && k <= n + 1) ? words[k-2] : 8'h00;
        check("alu_inbus", alu_inbus, w);
      end
      check("rsp_valid_early", rsp_valid, 1'b0);
      alu_end    = (k == end_at);
      alu_outbus = (k == end_at - 2) ? r_hi : (k == end_at - 1) ? r_lo : 8'hEE;
    end
    @(negedge clk);
    alu_end    = 1'b0;
    alu_outbus = 8'h00;
    check("rsp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = OP_MUL; req_a = 8'hFF; req_q = 8'hFF; req_m = 8'hFF;
      alu_end    = 1'b1;
      alu_outbus = 8'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_req_ready", req_ready, 1'b0);
      check("hold_rsp_hi", rsp_hi, exp_rsp.hi);
      check("hold_rsp_lo", rsp_lo, exp_rsp.lo);
      check("hold_alu_begin", alu_begin, 1'b0);
    end
    alu_end    = 1'b0;
    alu_outbus = 8'h00;
    rsp_ready  = 1'b1;
    exp_rsp = sb.pop_front();
    check("rsp_hi", rsp_hi, exp_rsp.hi);
    check("rsp_lo", rsp_lo, exp_rsp.lo);
    check("rsp_timeout", rsp_timeout, exp_rsp.to);
    check("done_req_ready", req_ready, 1'b0);
    check("done_alu_op_code", alu_op_code, op);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("after_rsp_valid", rsp_valid, 1'b0);
    check("after_busy", busy, 1'b0);
    check("after_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_q = 8'h00; req_m = 8'h00;
    alu_outbus = 8'h00; alu_end = 1'b0; rsp_ready = 1'b0;
    #1;
    check_all_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check("por_release_req_ready", req_ready, 1'b1);
    @(negedge clk);

    // Reset in the middle of feeding a divide.
    req_valid = 1'b1; req_op = OP_DIV; req_a = 8'h12; req_q = 8'h34; req_m = 8'h56;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midfeed_inbus", alu_inbus, 8'h12);
    #2 reset = 1'b0;
    #1 check_all_zero("midfeed_rst");
    @(negedge clk);
    reset = 1'b1;
    #1 check("midfeed_release_req_ready", req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midfeed_no_rsp", rsp_valid, 1'b0);
      check("midfeed_idle", busy, 1'b0);
    end

    do_op(OP_ADD, 8'h00, 8'h05, 8'h03, 6, 0);                // hi=00 lo=08
    do_op(OP_DIV, 8'h01, 8'h2C, 8'h0A, 8, 0);                // 300/10: hi=00 lo=1E
    do_op(OP_MUL, 8'h00, 8'h10, 8'h10, -1, 0);               // watchdog timeout
    do_op(OP_SUB, 8'h00, 8'h50, 8'h20, 7, 10);               // held response
    do_op(OP_MUL, 8'h00, 8'hF3, 8'h2B, 5, 0);                // back-to-back
    do_op(OP_ADD, 8'h00, 8'hFF, 8'h01, TIMEOUT_CYCLES, 0);   // END ties with expiry
    do_op(OP_DIV, 8'h00, 8'h07, 8'h02, 2, 0);                // earliest END, one slot empty
    do_op(OP_DIV, 8'h03, 8'hE8, 8'h07, 1, 0);                // END on START+1, both slots empty

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
